// File: rtl/vend_order_ctrl.sv
// vend_order_ctrl: cart-based vending controller. It builds an order from the switches,
// counts coin pulses, checks payment and pays change out one greedy coin per request.

// One slice per denomination: its contribution to this cycle's coin sum, and
// whether it could be paid out against the change still owed.
module vend_coin_lane #(
  parameter int MONEY_W = 8
) (
  input  logic [7:0]         denom,
  input  logic               coin,
  input  logic [MONEY_W-1:0] change,
  output logic [7:0]         coin_val,
  output logic               fits
);
  localparam int CW = MONEY_W + 8;

  assign coin_val = coin ? denom : 8'd0;
  assign fits     = (change != '0) && (CW'(denom) <= CW'(change));
endmodule

module vend_order_ctrl #(
  parameter int                  MONEY_W    = 8,
  parameter int                  TYPE_W     = 3,
  parameter int                  NUM_W      = 2,
  parameter int                  CART_DEPTH = 2,
  parameter int                  COIN_N     = 5,
  parameter logic [COIN_N*8-1:0] DENOMS     = {8'd50, 8'd20, 8'd10, 8'd5, 8'd1}
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst_n,
  input  logic                                sys_Goods,
  input  logic                                sys_Confirm,
  input  logic                                sys_Change,
  input  logic                                sys_Cancel,
  input  logic [COIN_N-1:0]                   in_money,
  input  logic [TYPE_W-1:0]                   type_SW_high,
  input  logic [TYPE_W-1:0]                   type_SW_low,
  input  logic [NUM_W-1:0]                    num_SW,
  output logic [MONEY_W-1:0]                  need_money,
  output logic [MONEY_W-1:0]                  input_money,
  output logic [MONEY_W-1:0]                  change_money,
  output logic [COIN_N-1:0]                   coin_out,
  output logic [$clog2(CART_DEPTH+1)-1:0]     cart_cnt,
  output logic                                vend_pulse,
  output logic                                err_pulse,
  output logic [5:0]                          state_out
);
  localparam int CNT_W   = $clog2(CART_DEPTH + 1);
  localparam int PRICE_W = TYPE_W + 4;
  localparam int COST_W  = PRICE_W + NUM_W;
  // Wide enough that neither cart sums nor a full handful of coins can wrap before the range check.
  localparam int WIDE_W  = MONEY_W + COST_W + 8 + $clog2(COIN_N + 1);
  localparam logic [WIDE_W-1:0] MONEY_MAX = {{(WIDE_W-MONEY_W){1'b0}}, {MONEY_W{1'b1}}};

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_SELECT = 6'b000010,
    S_PAY    = 6'b000100,
    S_VEND   = 6'b001000,
    S_CHANGE = 6'b010000,
    S_REFUND = 6'b100000
  } state_t;

  state_t state_q, state_d;

  logic [MONEY_W-1:0] need_d, input_d, change_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [COIN_N-1:0]  coin_d;
  logic               vend_d, err_d;

  logic [COIN_N-1:0][7:0] denom_v;
  logic [COIN_N-1:0][7:0] coin_val;
  logic [COIN_N-1:0]      fits;

  logic [WIDE_W-1:0]  cost_w, need_sum_w, coin_sum_w, pay_sum_w;
  logic [MONEY_W-1:0] pay_sat, pick_val;
  logic [COIN_N-1:0]  pick;
  logic               commit_ok, paid;

  assign denom_v = DENOMS;

  for (genvar i = 0; i < COIN_N; i++) begin : g_lane
    vend_coin_lane #(.MONEY_W(MONEY_W)) u_lane (
      .denom   (denom_v[i]),
      .coin    (in_money[i]),
      .change  (change_money),
      .coin_val(coin_val[i]),
      .fits    (fits[i])
    );
  end

  always_comb begin
    cost_w     = (WIDE_W'(type_SW_high) * WIDE_W'(10) + WIDE_W'(type_SW_low)) * WIDE_W'(num_SW);
    need_sum_w = WIDE_W'(need_money) + cost_w;
    commit_ok  = (num_SW != '0) && (cart_cnt != CNT_W'(CART_DEPTH)) && (need_sum_w <= MONEY_MAX);
    paid       = (input_money >= need_money);
  end

  always_comb begin
    coin_sum_w = '0;
    for (int i = 0; i < COIN_N; i++)
      coin_sum_w = coin_sum_w + WIDE_W'(coin_val[i]);
    pay_sum_w = WIDE_W'(input_money) + coin_sum_w;
    pay_sat   = (pay_sum_w > MONEY_MAX) ? {MONEY_W{1'b1}} : pay_sum_w[MONEY_W-1:0];
  end

  // Denominations ascend with index, so the last fitting lane is the largest coin.
  always_comb begin
    pick     = '0;
    pick_val = '0;
    for (int i = 0; i < COIN_N; i++)
      if (fits[i]) begin
        pick     = COIN_N'(1) << i;
        pick_val = MONEY_W'(denom_v[i]);
      end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      need_money   <= '0;
      input_money  <= '0;
      change_money <= '0;
      cart_cnt     <= '0;
      coin_out     <= '0;
      vend_pulse   <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      state_q      <= state_d;
      need_money   <= need_d;
      input_money  <= input_d;
      change_money <= change_d;
      cart_cnt     <= cnt_d;
      coin_out     <= coin_d;
      vend_pulse   <= vend_d;
      err_pulse    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (!sys_Cancel && sys_Confirm) state_d = S_SELECT;
      S_SELECT:
        if (sys_Cancel) state_d = S_IDLE;
        else if (sys_Confirm && (commit_ok || cart_cnt != '0)) state_d = S_PAY;
      S_PAY:
        if (sys_Cancel) state_d = S_REFUND;
        else if (sys_Confirm && paid) state_d = S_VEND;
      S_VEND:
        state_d = (change_money != '0) ? S_CHANGE : S_IDLE;
      S_CHANGE, S_REFUND:
        if (change_money == '0) state_d = S_IDLE;
        else if (sys_Change && pick_val == change_money) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    need_d   = need_money;
    input_d  = input_money;
    change_d = change_money;
    cnt_d    = cart_cnt;
    coin_d   = '0;
    err_d    = 1'b0;
    vend_d   = (state_d == S_VEND);
    case (state_q)
      S_IDLE:
        if (!sys_Cancel && sys_Confirm) begin
          need_d   = '0;
          input_d  = '0;
          change_d = '0;
          cnt_d    = '0;
        end
      S_SELECT:
        if (sys_Cancel) begin
          need_d   = '0;
          input_d  = '0;
          change_d = '0;
          cnt_d    = '0;
        end else if (sys_Confirm || sys_Goods) begin
          if (commit_ok) begin
            need_d = need_sum_w[MONEY_W-1:0];
            cnt_d  = cart_cnt + CNT_W'(1);
          end else begin
            // A failed commit on Confirm is only an error if it leaves nothing to pay for.
            err_d = sys_Confirm ? (cart_cnt == '0) : 1'b1;
          end
        end
      S_PAY:
        if (sys_Cancel) change_d = input_money;
        else if (sys_Confirm) begin
          if (paid) change_d = input_money - need_money;
          else      err_d    = 1'b1;
        end else input_d = pay_sat;
      S_CHANGE, S_REFUND:
        if (sys_Change && change_money != '0) begin
          coin_d   = pick;
          change_d = change_money - pick_val;
        end
      default: ;
    endcase
  end

  assign state_out = state_q;
endmodule

// File: tb/tb_vend_order_ctrl.sv
// Bench for vend_order_ctrl: vector table through an expected-result queue, then a
// bounded change-payout sequence checked against fixed totals.
module tb_vend_order_ctrl;
  localparam logic [5:0] ID = 6'b000001, SE = 6'b000010, PA = 6'b000100;
  localparam logic [5:0] VE = 6'b001000, CH = 6'b010000, RF = 6'b100000;

  logic       sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic       sys_Goods = 1'b0, sys_Confirm = 1'b0, sys_Change = 1'b0, sys_Cancel = 1'b0;
  logic [4:0] in_money = '0;
  logic [2:0] type_SW_high = '0, type_SW_low = '0;
  logic [1:0] num_SW = '0;
  logic [7:0] need_money, input_money, change_money;
  logic [4:0] coin_out;
  logic [1:0] cart_cnt;
  logic       vend_pulse, err_pulse;
  logic [5:0] state_out;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic       rst, cf, gd, ch, cn;
    logic [4:0] coins;
    logic [2:0] hi, lo;
    logic [1:0] num;
    logic [7:0] need, inm, chg;
    logic [4:0] cout;
    logic [1:0] cnt;
    logic       vend, err;
    logic [5:0] st;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  vend_order_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_Goods(sys_Goods), .sys_Confirm(sys_Confirm),
    .sys_Change(sys_Change), .sys_Cancel(sys_Cancel), .in_money(in_money),
    .type_SW_high(type_SW_high), .type_SW_low(type_SW_low), .num_SW(num_SW),
    .need_money(need_money), .input_money(input_money), .change_money(change_money),
    .coin_out(coin_out), .cart_cnt(cart_cnt), .vend_pulse(vend_pulse), .err_pulse(err_pulse),
    .state_out(state_out)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic void add(input logic rst, cf, gd, ch, cn, input logic [4:0] coins,
                              input logic [2:0] hi, lo, input logic [1:0] num,
                              input logic [7:0] need, inm, chg, input logic [4:0] cout,
                              input logic [1:0] cnt, input logic vend, err, input logic [5:0] st);
    vec_t v;
    v.rst = rst; v.cf = cf; v.gd = gd; v.ch = ch; v.cn = cn; v.coins = coins;
    v.hi = hi; v.lo = lo; v.num = num; v.need = need; v.inm = inm; v.chg = chg;
    v.cout = cout; v.cnt = cnt; v.vend = vend; v.err = err; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", nm, idx, got, exp);
    end
  endtask

  task automatic drive(input logic rst, cf, gd, ch, cn, input logic [4:0] coins,
                       input logic [2:0] hi, lo, input logic [1:0] num);
    @(negedge sys_clk);
    sys_rst_n = !rst; sys_Confirm = cf; sys_Goods = gd; sys_Change = ch; sys_Cancel = cn;
    in_money = coins; type_SW_high = hi; type_SW_low = lo; num_SW = num;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1; sys_Confirm = 1'b0; sys_Goods = 1'b0; sys_Change = 1'b0;
    sys_Cancel = 1'b0; in_money = '0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    exp_q.push_back(v);
    drive(v.rst, v.cf, v.gd, v.ch, v.cn, v.coins, v.hi, v.lo, v.num);
    e = exp_q.pop_front();
    chk("need_money",   idx, 32'(need_money),   32'(e.need));
    chk("input_money",  idx, 32'(input_money),  32'(e.inm));
    chk("change_money", idx, 32'(change_money), 32'(e.chg));
    chk("coin_out",     idx, 32'(coin_out),     32'(e.cout));
    chk("cart_cnt",     idx, 32'(cart_cnt),     32'(e.cnt));
    chk("vend_pulse",   idx, 32'(vend_pulse),   32'(e.vend));
    chk("err_pulse",    idx, 32'(err_pulse),    32'(e.err));
    chk("state_out",    idx, 32'(state_out),    32'(e.st));
  endtask

  initial begin
    int total, presses, bad;

    //   rst cf gd ch cn coins     hi lo num  need inm chg  cout      cnt vend err st
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,    0,   0,  0, 5'b00000, 0, 0, 0, SE);
    add(0, 0, 1, 0, 0, 5'b00000, 2, 1, 3,   63,   0,  0, 5'b00000, 1, 0, 0, SE);
    add(0, 1, 0, 0, 0, 5'b00000, 3, 3, 1,   96,   0,  0, 5'b00000, 2, 0, 0, PA);
    add(0, 0, 0, 0, 0, 5'b00001, 0, 0, 0,   96,   1,  0, 5'b00000, 2, 0, 0, PA);
    add(0, 0, 0, 0, 0, 5'b00010, 0, 0, 0,   96,   6,  0, 5'b00000, 2, 0, 0, PA);
    add(0, 0, 0, 0, 0, 5'b00100, 0, 0, 0,   96,  16,  0, 5'b00000, 2, 0, 0, PA);
    add(0, 0, 0, 0, 0, 5'b01000, 0, 0, 0,   96,  36,  0, 5'b00000, 2, 0, 0, PA);
    add(0, 0, 0, 0, 0, 5'b10000, 0, 0, 0,   96,  86,  0, 5'b00000, 2, 0, 0, PA);
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,   96,  86,  0, 5'b00000, 2, 0, 1, PA);
    add(0, 0, 0, 0, 0, 5'b01000, 0, 0, 0,   96, 106,  0, 5'b00000, 2, 0, 0, PA);
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,   96, 106, 10, 5'b00000, 2, 1, 0, VE);
    add(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0,   96, 106, 10, 5'b00000, 2, 0, 0, CH);
    add(0, 0, 0, 1, 0, 5'b00000, 0, 0, 0,   96, 106,  0, 5'b00100, 2, 0, 0, ID);
    // greedy change of 37, with ignored actions mid-payout
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,    0,   0,  0, 5'b00000, 0, 0, 0, SE);
    add(0, 1, 0, 0, 0, 5'b00000, 1, 3, 1,   13,   0,  0, 5'b00000, 1, 0, 0, PA);
    add(0, 0, 0, 0, 0, 5'b10000, 0, 0, 0,   13,  50,  0, 5'b00000, 1, 0, 0, PA);
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,   13,  50, 37, 5'b00000, 1, 1, 0, VE);
    add(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0,   13,  50, 37, 5'b00000, 1, 0, 0, CH);
    add(0, 0, 0, 1, 0, 5'b00000, 0, 0, 0,   13,  50, 17, 5'b01000, 1, 0, 0, CH);
    add(0, 1, 1, 0, 1, 5'b10000, 2, 2, 1,   13,  50, 17, 5'b00000, 1, 0, 0, CH);
    add(0, 0, 0, 1, 0, 5'b00000, 0, 0, 0,   13,  50,  7, 5'b00100, 1, 0, 0, CH);
    add(0, 0, 0, 1, 0, 5'b00000, 0, 0, 0,   13,  50,  2, 5'b00010, 1, 0, 0, CH);
    add(0, 0, 0, 1, 0, 5'b00000, 0, 0, 0,   13,  50,  1, 5'b00001, 1, 0, 0, CH);
    add(0, 0, 0, 1, 0, 5'b00000, 0, 0, 0,   13,  50,  0, 5'b00001, 1, 0, 0, ID);
    add(0, 0, 0, 1, 0, 5'b00000, 0, 0, 0,   13,  50,  0, 5'b00000, 1, 0, 0, ID);
    // overflow, full cart, rejected commit on Confirm with a nonempty cart
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,    0,   0,  0, 5'b00000, 0, 0, 0, SE);
    add(0, 0, 1, 0, 0, 5'b00000, 7, 7, 3,  231,   0,  0, 5'b00000, 1, 0, 0, SE);
    add(0, 0, 1, 0, 0, 5'b00000, 7, 7, 1,  231,   0,  0, 5'b00000, 1, 0, 1, SE);
    add(0, 0, 1, 0, 0, 5'b00000, 1, 0, 1,  241,   0,  0, 5'b00000, 2, 0, 0, SE);
    add(0, 0, 1, 0, 0, 5'b00000, 1, 0, 1,  241,   0,  0, 5'b00000, 2, 0, 1, SE);
    add(0, 1, 0, 0, 0, 5'b00000, 1, 0, 1,  241,   0,  0, 5'b00000, 2, 0, 0, PA);
    add(0, 0, 0, 0, 1, 5'b00000, 0, 0, 0,  241,   0,  0, 5'b00000, 2, 0, 0, RF);
    add(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0,  241,   0,  0, 5'b00000, 2, 0, 0, ID);
    // zero quantity, empty-cart confirm
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,    0,   0,  0, 5'b00000, 0, 0, 0, SE);
    add(0, 1, 0, 0, 0, 5'b00000, 2, 5, 0,    0,   0,  0, 5'b00000, 0, 0, 1, SE);
    add(0, 0, 1, 0, 0, 5'b00000, 2, 5, 0,    0,   0,  0, 5'b00000, 0, 0, 1, SE);
    add(0, 0, 1, 0, 0, 5'b00000, 2, 5, 1,   25,   0,  0, 5'b00000, 1, 0, 0, SE);
    add(0, 1, 0, 0, 0, 5'b00000, 3, 0, 0,   25,   0,  0, 5'b00000, 1, 0, 0, PA);
    // refund of 25
    add(0, 0, 0, 0, 0, 5'b01010, 0, 0, 0,   25,  25,  0, 5'b00000, 1, 0, 0, PA);
    add(0, 0, 0, 0, 1, 5'b00000, 0, 0, 0,   25,  25, 25, 5'b00000, 1, 0, 0, RF);
    add(0, 0, 0, 1, 0, 5'b00000, 0, 0, 0,   25,  25,  5, 5'b01000, 1, 0, 0, RF);
    add(0, 0, 0, 1, 0, 5'b00000, 0, 0, 0,   25,  25,  0, 5'b00010, 1, 0, 0, ID);
    // input saturation, Cancel beating Confirm in PAY, reset out of REFUND
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,    0,   0,  0, 5'b00000, 0, 0, 0, SE);
    add(0, 0, 1, 0, 0, 5'b00000, 1, 0, 1,   10,   0,  0, 5'b00000, 1, 0, 0, SE);
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,   10,   0,  0, 5'b00000, 1, 0, 0, PA);
    add(0, 0, 0, 0, 0, 5'b11111, 0, 0, 0,   10,  86,  0, 5'b00000, 1, 0, 0, PA);
    add(0, 0, 0, 0, 0, 5'b11111, 0, 0, 0,   10, 172,  0, 5'b00000, 1, 0, 0, PA);
    add(0, 0, 0, 0, 0, 5'b11111, 0, 0, 0,   10, 255,  0, 5'b00000, 1, 0, 0, PA);
    add(0, 1, 0, 0, 1, 5'b00000, 0, 0, 0,   10, 255,255, 5'b00000, 1, 0, 0, RF);
    add(0, 0, 0, 1, 0, 5'b00000, 0, 0, 0,   10, 255,205, 5'b10000, 1, 0, 0, RF);
    add(1, 0, 0, 0, 0, 5'b00000, 0, 0, 0,    0,   0,  0, 5'b00000, 0, 0, 0, ID);
    // reset in the middle of CHANGE with 30 owed
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,    0,   0,  0, 5'b00000, 0, 0, 0, SE);
    add(0, 1, 0, 0, 0, 5'b00000, 2, 0, 1,   20,   0,  0, 5'b00000, 1, 0, 0, PA);
    add(0, 0, 0, 0, 0, 5'b10000, 0, 0, 0,   20,  50,  0, 5'b00000, 1, 0, 0, PA);
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,   20,  50, 30, 5'b00000, 1, 1, 0, VE);
    add(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0,   20,  50, 30, 5'b00000, 1, 0, 0, CH);
    add(1, 0, 0, 1, 0, 5'b00000, 0, 0, 0,    0,   0,  0, 5'b00000, 0, 0, 0, ID);
    // Cancel+Confirm in SELECT, exact payment with no change
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,    0,   0,  0, 5'b00000, 0, 0, 0, SE);
    add(0, 1, 0, 0, 1, 5'b00000, 2, 0, 1,    0,   0,  0, 5'b00000, 0, 0, 0, ID);
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,    0,   0,  0, 5'b00000, 0, 0, 0, SE);
    add(0, 1, 0, 0, 0, 5'b00000, 1, 0, 1,   10,   0,  0, 5'b00000, 1, 0, 0, PA);
    add(0, 0, 0, 0, 0, 5'b00100, 0, 0, 0,   10,  10,  0, 5'b00000, 1, 0, 0, PA);
    add(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0,   10,  10,  0, 5'b00000, 1, 1, 0, VE);
    add(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0,   10,  10,  0, 5'b00000, 1, 0, 0, ID);

    // reset state
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset_state",  -1, 32'(state_out), 32'(ID));
    chk("reset_need",   -1, 32'(need_money), 32'd0);
    chk("reset_input",  -1, 32'(input_money), 32'd0);
    chk("reset_change", -1, 32'(change_money), 32'd0);
    chk("reset_pulses", -1, 32'({coin_out, cart_cnt, vend_pulse, err_pulse}), 32'd0);
    sys_rst_n = 1'b1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Payout of 49 change: 20+20+5+1+1+1+1, bounded by a press budget.
    drive(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 5'b00000, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 5'b10000, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0);
    chk("seq_vend", 100, 32'(vend_pulse), 32'd1);
    chk("seq_change_owed", 100, 32'(change_money), 32'd49);
    drive(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
    chk("seq_in_change", 100, 32'(state_out), 32'(CH));
    total = 0; presses = 0; bad = 0;
    for (int k = 0; k < 20 && state_out != ID; k++) begin
      drive(0, 0, 0, 1, 0, 5'b00000, 0, 0, 0);
      presses++;
      case (coin_out)
        5'b00001: total += 1;
        5'b00010: total += 5;
        5'b00100: total += 10;
        5'b01000: total += 20;
        5'b10000: total += 50;
        default:  bad++;
      endcase
    end
    chk("seq_payout_total", 100, 32'(total), 32'd49);
    chk("seq_presses", 100, 32'(presses), 32'd7);
    chk("seq_coin_onehot", 100, 32'(bad), 32'd0);
    chk("seq_final_state", 100, 32'(state_out), 32'(ID));
    chk("seq_final_change", 100, 32'(change_money), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
